// File: rtl/control_sequencer_if.sv
// Bus bundle for the control sequencer: instruction/stall/irq inputs and
// the registered micro-state, step, opcode and pulse outputs.
interface control_sequencer_if #(
  parameter int unsigned IW  = 16,
  parameter int unsigned OPW = 4,
  parameter int unsigned SW  = 8
) ();

  logic [IW-1:0]  instr;
  logic           stall;
  logic           irq;
  logic [SW-1:0]  state;
  logic [2:0]     step;
  logic [OPW-1:0] opcode_q;
  logic           instr_done;
  logic           illegal;
  logic           irq_ack;

  modport master (
    output instr, stall, irq,
    input  state, step, opcode_q, instr_done, illegal, irq_ack
  );

  modport slave (
    input  instr, stall, irq,
    output state, step, opcode_q, instr_done, illegal, irq_ack
  );

endinterface

// File: rtl/control_sequencer.sv
// Microcoded control sequencer: fetch/decode path, per-opcode execution
// chains, an interrupt chain, and registered completion/illegal/ack pulses.
module control_sequencer #(
  parameter int unsigned IW  = 16,
  parameter int unsigned OPW = 4,
  parameter int unsigned SW  = 8
) (
  input logic                clk,
  input logic                resetn,
  control_sequencer_if.slave bus
);

  typedef enum logic [SW-1:0] {
    ST_IDLE  = SW'(6'h00), ST_DEC   = SW'(6'h01), ST_LD    = SW'(6'h02),
    ST_MOV   = SW'(6'h03), ST_LDPC  = SW'(6'h04), ST_BR    = SW'(6'h05),
    ST_SUB0  = SW'(6'h06), ST_SUB1  = SW'(6'h07), ST_SUB2  = SW'(6'h08),
    ST_ADD0  = SW'(6'h09), ST_ADD1  = SW'(6'h0A), ST_ADD2  = SW'(6'h0B),
    ST_XOR0  = SW'(6'h0C), ST_XOR1  = SW'(6'h0D), ST_XOR2  = SW'(6'h0E),
    ST_FETCH = SW'(6'h0F),
    ST_PUSH0 = SW'(6'h13), ST_PUSH1 = SW'(6'h14), ST_PUSH2 = SW'(6'h15),
    ST_PUSH3 = SW'(6'h16),
    ST_POP0  = SW'(6'h17), ST_POP1  = SW'(6'h18), ST_POP2  = SW'(6'h19),
    ST_POP3  = SW'(6'h1A),
    ST_CALL0 = SW'(6'h1B), ST_CALL1 = SW'(6'h1C), ST_CALL2 = SW'(6'h1D),
    ST_CALL3 = SW'(6'h1E), ST_CALL4 = SW'(6'h1F), ST_CALL5 = SW'(6'h20),
    ST_RET0  = SW'(6'h21), ST_RET1  = SW'(6'h22), ST_RET2  = SW'(6'h23),
    ST_RET3  = SW'(6'h24),
    ST_IRQ0  = SW'(6'h25), ST_IRQ1  = SW'(6'h26), ST_IRQ2  = SW'(6'h27),
    ST_IRQ3  = SW'(6'h28)
  } state_e;

  state_e         state_q, state_d;
  logic [2:0]     step_q, step_d;
  logic [OPW-1:0] opcode_q, opcode_d;
  logic           done_q, done_d;
  logic           ill_q, ill_d;
  logic           ack_q, ack_d;

  logic [OPW-1:0] op;
  logic           op_ext_zero;

  assign op          = bus.instr[IW-1 -: OPW];
  // Opcodes wider than 4 bits are legal only when the extension bits are zero
  assign op_ext_zero = ((op >> 4) == '0);

  // Next-state, step and pulse decode; a stall freezes everything and kills pulses
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    opcode_d = opcode_q;
    done_d   = 1'b0;
    ill_d    = 1'b0;
    ack_d    = 1'b0;
    if (!bus.stall) begin
      state_d = ST_IDLE;
      step_d  = '0;
      case (state_q)
        ST_IDLE: begin
          if (bus.irq) begin
            state_d = ST_IRQ0;
            ack_d   = 1'b1;
          end else begin
            state_d = ST_FETCH;
          end
        end
        ST_FETCH: state_d = ST_DEC;
        ST_DEC: begin
          opcode_d = op;
          if (op_ext_zero) begin
            case (op[3:0])
              4'h0:    state_d = ST_LD;
              4'h1:    state_d = ST_MOV;
              4'h2:    state_d = ST_ADD0;
              4'h3:    state_d = ST_SUB0;
              4'h4:    state_d = ST_XOR0;
              4'h5:    state_d = ST_LDPC;
              4'h6:    state_d = ST_BR;
              4'h8:    state_d = ST_PUSH0;
              4'h9:    state_d = ST_POP0;
              4'hA:    state_d = ST_CALL0;
              4'hB:    state_d = ST_RET0;
              default: ill_d   = 1'b1;
            endcase
          end else begin
            ill_d = 1'b1;
          end
        end
        // Chain encodings are consecutive, so mid-chain states just advance by one
        ST_SUB0, ST_SUB1, ST_ADD0, ST_ADD1, ST_XOR0, ST_XOR1,
        ST_PUSH0, ST_PUSH1, ST_PUSH2, ST_POP0, ST_POP1, ST_POP2,
        ST_CALL0, ST_CALL1, ST_CALL2, ST_CALL3, ST_CALL4,
        ST_RET0, ST_RET1, ST_RET2: begin
          state_d = state_e'(state_q + SW'(1));
          step_d  = step_q + 3'd1;
        end
        ST_IRQ0, ST_IRQ1, ST_IRQ2: state_d = state_e'(state_q + SW'(1));
        ST_LD, ST_MOV, ST_LDPC, ST_BR, ST_SUB2, ST_ADD2, ST_XOR2,
        ST_PUSH3, ST_POP3, ST_CALL5, ST_RET3: done_d = 1'b1;
        default: ;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      step_q   <= '0;
      opcode_q <= '0;
      done_q   <= 1'b0;
      ill_q    <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      opcode_q <= opcode_d;
      done_q   <= done_d;
      ill_q    <= ill_d;
      ack_q    <= ack_d;
    end
  end

  assign bus.state      = state_q;
  assign bus.step       = step_q;
  assign bus.opcode_q   = opcode_q;
  assign bus.instr_done = done_q;
  assign bus.illegal    = ill_q;
  assign bus.irq_ack    = ack_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed vector bench for control_sequencer: table of per-edge stimulus and
// expected outputs, plus hand sequences for async reset mid-chain.
module tb_control_sequencer;

  localparam int unsigned IW  = 16;
  localparam int unsigned OPW = 4;
  localparam int unsigned SW  = 8;

  logic clk;
  logic resetn;
  int   total;
  int   bad;

  control_sequencer_if #(.IW(IW), .OPW(OPW), .SW(SW)) bus ();

  control_sequencer #(.IW(IW), .OPW(OPW), .SW(SW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic        stall;
    logic        irq;
    logic [7:0]  st;
    logic [2:0]  stp;
    logic [3:0]  op;
    logic        done;
    logic        ill;
    logic        ack;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [15:0] i, input logic s, input logic q,
                     input logic [7:0] st, input logic [2:0] stp, input logic [3:0] op,
                     input logic d, input logic l, input logic a);
    vec_t v;
    v.instr = i; v.stall = s; v.irq = q;
    v.st = st; v.stp = stp; v.op = op;
    v.done = d; v.ill = l; v.ack = a;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] st, input logic [2:0] stp,
                         input logic [3:0] op, input logic d, input logic l, input logic a);
    chk({tag, ".state"},      32'(bus.state),      32'(st));
    chk({tag, ".step"},       32'(bus.step),       32'(stp));
    chk({tag, ".opcode_q"},   32'(bus.opcode_q),   32'(op));
    chk({tag, ".instr_done"}, 32'(bus.instr_done), 32'(d));
    chk({tag, ".illegal"},    32'(bus.illegal),    32'(l));
    chk({tag, ".irq_ack"},    32'(bus.irq_ack),    32'(a));
  endtask

  // Drive inputs, take one rising edge, sample just after it
  task automatic apply(input string tag, input vec_t v);
    bus.instr = v.instr;
    bus.stall = v.stall;
    bus.irq   = v.irq;
    @(posedge clk);
    #1;
    chk_all(tag, v.st, v.stp, v.op, v.done, v.ill, v.ack);
  endtask

  initial begin
    vec_t h;
    total = 0;
    bad   = 0;

    // instr, stall, irq -> state, step, opcode_q, done, illegal, ack
    // ADD: 00,0F,01,09,0A,0B,00
    add(16'h2345, 0, 0, 8'h0F, 0, 4'h0, 0, 0, 0);
    add(16'h2345, 0, 0, 8'h01, 0, 4'h0, 0, 0, 0);
    add(16'h2345, 0, 0, 8'h09, 0, 4'h2, 0, 0, 0);
    add(16'h2345, 0, 0, 8'h0A, 1, 4'h2, 0, 0, 0);
    add(16'h2345, 0, 0, 8'h0B, 2, 4'h2, 0, 0, 0);
    add(16'h2345, 0, 0, 8'h00, 0, 4'h2, 1, 0, 0);
    // illegal 0xD
    add(16'hD000, 0, 0, 8'h0F, 0, 4'h2, 0, 0, 0);
    add(16'hD000, 0, 0, 8'h01, 0, 4'h2, 0, 0, 0);
    add(16'hD000, 0, 0, 8'h00, 0, 4'hD, 0, 1, 0);
    // interrupt chain, then fetch resumes
    add(16'hD000, 0, 1, 8'h25, 0, 4'hD, 0, 0, 1);
    add(16'hD000, 0, 0, 8'h26, 0, 4'hD, 0, 0, 0);
    add(16'hD000, 0, 0, 8'h27, 0, 4'hD, 0, 0, 0);
    add(16'hD000, 0, 0, 8'h28, 0, 4'hD, 0, 0, 0);
    add(16'hD000, 0, 0, 8'h00, 0, 4'hD, 0, 0, 0);
    add(16'hA000, 0, 0, 8'h0F, 0, 4'hD, 0, 0, 0);
    // CALL with two stalled cycles in 0x1D
    add(16'hA000, 0, 0, 8'h01, 0, 4'hD, 0, 0, 0);
    add(16'hA000, 0, 0, 8'h1B, 0, 4'hA, 0, 0, 0);
    add(16'hA000, 0, 0, 8'h1C, 1, 4'hA, 0, 0, 0);
    add(16'hA000, 0, 0, 8'h1D, 2, 4'hA, 0, 0, 0);
    add(16'hA000, 1, 0, 8'h1D, 2, 4'hA, 0, 0, 0);
    add(16'hA000, 1, 0, 8'h1D, 2, 4'hA, 0, 0, 0);
    add(16'hA000, 0, 0, 8'h1E, 3, 4'hA, 0, 0, 0);
    add(16'hA000, 0, 0, 8'h1F, 4, 4'hA, 0, 0, 0);
    add(16'hA000, 0, 0, 8'h20, 5, 4'hA, 0, 0, 0);
    add(16'hA000, 0, 0, 8'h00, 0, 4'hA, 1, 0, 0);
    // PUSH, instr switches to MOV after decode
    add(16'h8000, 0, 0, 8'h0F, 0, 4'hA, 0, 0, 0);
    add(16'h8000, 0, 0, 8'h01, 0, 4'hA, 0, 0, 0);
    add(16'h8000, 0, 0, 8'h13, 0, 4'h8, 0, 0, 0);
    add(16'h1000, 0, 0, 8'h14, 1, 4'h8, 0, 0, 0);
    add(16'h1000, 0, 0, 8'h15, 2, 4'h8, 0, 0, 0);
    add(16'h1000, 0, 0, 8'h16, 3, 4'h8, 0, 0, 0);
    add(16'h1000, 0, 0, 8'h00, 0, 4'h8, 1, 0, 0);
    // stall in 0x00 ignores irq and clears the pulse
    add(16'h1000, 1, 1, 8'h00, 0, 4'h8, 0, 0, 0);
    add(16'h1000, 0, 0, 8'h0F, 0, 4'h8, 0, 0, 0);
    // opcode 7 illegal
    add(16'h7000, 0, 0, 8'h01, 0, 4'h8, 0, 0, 0);
    add(16'h7000, 0, 0, 8'h00, 0, 4'h7, 0, 1, 0);
    // LD: shortest chain
    add(16'h0000, 0, 0, 8'h0F, 0, 4'h7, 0, 0, 0);
    add(16'h0000, 0, 0, 8'h01, 0, 4'h7, 0, 0, 0);
    add(16'h0000, 0, 0, 8'h02, 0, 4'h0, 0, 0, 0);
    add(16'h0000, 0, 0, 8'h00, 0, 4'h0, 1, 0, 0);

    resetn    = 1'b0;
    bus.instr = 16'h0000;
    bus.stall = 1'b0;
    bus.irq   = 1'b0;
    #12;
    chk_all("reset", 8'h00, 0, 4'h0, 0, 0, 0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      apply($sformatf("vec%0d", i), vecs[i]);

    // POP up to 0x18, then async reset between edges
    h = '{16'h9000, 0, 0, 8'h0F, 0, 4'h0, 0, 0, 0};
    apply("pop0", h);
    h.st = 8'h01;
    apply("pop1", h);
    h.st = 8'h17; h.op = 4'h9;
    apply("pop2", h);
    h.st = 8'h18; h.stp = 1;
    apply("pop3", h);
    #3;
    resetn = 1'b0;
    #1;
    chk_all("async_rst", 8'h00, 0, 4'h0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_all("rst_hold", 8'h00, 0, 4'h0, 0, 0, 0);

    // irq high at reset release goes straight to the interrupt chain
    bus.irq = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    chk_all("rst_irq", 8'h25, 0, 4'h0, 0, 0, 1);
    h = '{16'h9000, 0, 0, 8'h26, 0, 4'h0, 0, 0, 0};
    apply("irq1", h);
    h.st = 8'h27;
    apply("irq2", h);
    h.st = 8'h28;
    apply("irq3", h);
    h.st = 8'h00;
    apply("irq4", h);
    h.st = 8'h0F;
    apply("irq5", h);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
